// File: rtl/pdm_capture_if.sv
// rtl/pdm_capture_if.sv - sample RAM write port bundle
//
// Ports (modport master = writer, slave = RAM side):
//   ram_we      write strobe, one cycle per sample
//   ram_wraddr  sample word address
//   ram_wrdata  amplitude sample
interface pdm_capture_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              ram_we;
    logic [ADDR_W-1:0] ram_wraddr;
    logic [DATA_W-1:0] ram_wrdata;

    modport master (
        output ram_we,
        output ram_wraddr,
        output ram_wrdata
    );

    modport slave (
        input ram_we,
        input ram_wraddr,
        input ram_wrdata
    );
endinterface

// File: rtl/pdm_capture.sv
// rtl/pdm_capture.sv - PDM microphone capture into the sample RAM
//
// Clocks a PDM MEMS microphone, counts ones over windows of SAMPLE_COUNT
// bits and writes one amplitude word per window into the sample RAM.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start_capture   asynchronous pushbutton, rising edge starts a capture
//   m_clk           registered microphone clock, period CLK_COUNT clocks
//   m_lr_sel        microphone channel select, always 0
//   m_data          PDM bit stream from the microphone
//   ram             sample RAM write port (ram_we / ram_wraddr / ram_wrdata)
//   capture_active  high while a capture is in progress
//   capture_done    one-cycle pulse after the last word is written
//   led             16-LED buffer fill indicator
module pdm_capture #(
    parameter int CLK_FREQ = 100,
    parameter int RAM_SIZE = 16384
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_capture,
    output logic                m_clk,
    output logic                m_lr_sel,
    input  logic                m_data,
    pdm_capture_if.master       ram,
    output logic                capture_active,
    output logic                capture_done,
    output logic [15:0]         led
);

    localparam int SAMPLE_COUNT = 128;
    localparam int INPUT_FREQ   = 24000;
    localparam int SAMPLE_BITS  = $clog2(SAMPLE_COUNT + 1);
    localparam int CLK_COUNT    = (CLK_FREQ * 1000000) / (INPUT_FREQ * SAMPLE_COUNT);
    localparam int HALF         = CLK_COUNT / 2;
    localparam int CNT_W        = $clog2(CLK_COUNT);
    localparam int BIT_W        = $clog2(SAMPLE_COUNT);
    localparam int ADDR_W       = $clog2(RAM_SIZE);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_CAPTURE = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [CNT_W-1:0]        clk_counter;
    logic [CNT_W-1:0]        cnt_next;
    logic                    tick;

    logic [2:0]              sync;
    logic                    start_edge;

    logic [SAMPLE_BITS-1:0]  ones_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    ram_we_r;
    logic [ADDR_W-1:0]       ram_wraddr_r;
    logic [SAMPLE_BITS-1:0]  ram_wrdata_r;
    logic                    last_write;
    logic [3:0]              led_idx;

    assign m_lr_sel       = 1'b0;
    assign ram.ram_we     = ram_we_r;
    assign ram.ram_wraddr = ram_wraddr_r;
    assign ram.ram_wrdata = ram_wrdata_r;

    // Microphone clock generation; the counter never stops, even in IDLE,
    // so the microphone stays powered and settled between captures.
    assign cnt_next = (clk_counter == CNT_W'(CLK_COUNT - 1)) ? '0
                                                             : clk_counter + CNT_W'(1);

    // Last low cycle before m_clk rises: data is stable mid-low-phase.
    assign tick = (clk_counter == CNT_W'(HALF - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_counter <= '0;
            m_clk       <= 1'b0;
        end else begin
            clk_counter <= cnt_next;
            // Registered from the next count so m_clk tracks the counter phase
            // of the same cycle.
            m_clk       <= (cnt_next >= CNT_W'(HALF));
        end
    end

    // Pushbutton synchronizer and rising-edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], start_capture};
        end
    end

    assign start_edge = sync[1] & ~sync[2];

    // Write cycle of the final buffer word.
    assign last_write = ram_we_r && (ram_wraddr_r == ADDR_W'(RAM_SIZE - 1));

    // Top four address bits select the LED; narrow buffers are padded with
    // zeros below so the lights still spread across the bar.
    assign led_idx = 4'({ram_wraddr_r, 4'b0000} >> ADDR_W);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (last_write) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        capture_active = 1'b0;
        if (state == S_CAPTURE) begin
            capture_active = 1'b1;
        end
    end

    // Sample accumulation and RAM write datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_cnt     <= '0;
            bit_cnt      <= '0;
            ram_we_r     <= 1'b0;
            ram_wraddr_r <= '0;
            ram_wrdata_r <= '0;
            capture_done <= 1'b0;
            led          <= '0;
        end else begin
            ram_we_r     <= 1'b0;
            capture_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Ticks in IDLE are never counted, including one that
                    // coincides with the start edge.
                    if (start_edge) begin
                        ones_cnt     <= '0;
                        bit_cnt      <= '0;
                        ram_wraddr_r <= '0;
                        led          <= '0;
                    end
                end
                S_CAPTURE: begin
                    // Address advances once the write strobe has been seen.
                    if (ram_we_r) begin
                        if (last_write) begin
                            ram_wraddr_r <= '0;
                            capture_done <= 1'b1;
                        end else begin
                            ram_wraddr_r <= ram_wraddr_r + ADDR_W'(1);
                        end
                    end
                    if (tick) begin
                        if (bit_cnt == BIT_W'(SAMPLE_COUNT - 1)) begin
                            // Fold the window's final bit straight into the sample.
                            ram_wrdata_r <= ones_cnt + SAMPLE_BITS'(m_data);
                            ram_we_r     <= 1'b1;
                            ones_cnt     <= '0;
                            bit_cnt      <= '0;
                            led[~led_idx] <= 1'b1;
                        end else begin
                            ones_cnt <= ones_cnt + SAMPLE_BITS'(m_data);
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    ram_we_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pdm_capture.md
Name: pdm_capture

Overview:
- Upstream stage of the audio record/playback path: clocks a PDM MEMS microphone, counts ones over fixed windows, and writes one amplitude sample per window into the sample RAM.
- The PWM playback stage later reads that RAM.
- Window length and sample rate match the playback stage, so a full buffer records and replays in real time.
- Drives a 16-LED fill indicator that the playback stage clears in the same bit order.

Parameters:
- CLK_FREQ, 100, system clock frequency in MHz.
- RAM_SIZE, 16384, number of sample words to capture; RAM_SIZE >= 2.
- SAMPLE_COUNT, 128, localparam, PDM bits per amplitude sample.
- INPUT_FREQ, 24000, localparam, amplitude sample rate in Hz.
- SAMPLE_BITS, $clog2(SAMPLE_COUNT+1) = 8, localparam, amplitude width.
- CLK_COUNT, CLK_FREQ*1e6/(INPUT_FREQ*SAMPLE_COUNT) = 32, localparam, system clocks per m_clk period; must be even and >= 4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_capture  in  1  asynchronous pushbutton; a rising edge starts capture
- m_clk  out  1  PDM microphone clock, registered
- m_lr_sel  out  1  microphone channel select, tied 0
- m_data  in  1  PDM data from microphone
- ram_we  out  1  RAM write strobe, one cycle per sample
- ram_wraddr  out  $clog2(RAM_SIZE)  RAM write address
- ram_wrdata  out  SAMPLE_BITS  amplitude, range 0..SAMPLE_COUNT
- capture_active  out  1  high while capturing
- capture_done  out  1  one-cycle pulse after the last word is written
- led  out  16  buffer fill indicator

Behaviour:
- Reset: all outputs 0; internal counters 0; FSM in IDLE; sync chain cleared.
- clk_counter free-runs 0..CLK_COUNT-1 in all states, including IDLE.
- m_clk is registered. It is 1 on cycles where clk_counter is in [CLK_COUNT/2, CLK_COUNT-1], otherwise 0. Result: 50% duty, period CLK_COUNT (32 clocks = 3.125 MHz at the defaults).
- tick: asserted on the cycle where clk_counter == CLK_COUNT/2-1, i.e. the last low cycle before m_clk rises. m_data is sampled only on tick.
- start_capture passes through a 3-flop synchronizer. Edge is detected on sync[2:1] == 01.
- FSM states: IDLE, CAPTURE.
  - IDLE -> CAPTURE on start edge. Same cycle: ones_cnt, bit_cnt and ram_wraddr set to 0; led cleared to 0; capture_active goes to 1 on the next cycle.
  - CAPTURE, on each tick: ones_cnt += m_data; bit_cnt += 1.
  - On a tick where bit_cnt == SAMPLE_COUNT-1:
    - ram_wrdata <= ones_cnt + m_data (0..128; no overflow in SAMPLE_BITS).
    - ram_we <= 1 for exactly one cycle; ram_wraddr holds the address being written during that cycle.
    - ones_cnt and bit_cnt <= 0.
    - led[~ram_wraddr[MSB:MSB-3]] <= 1.
  - The cycle after a write: ram_wraddr increments.
  - If the written address was RAM_SIZE-1: ram_wraddr <= 0, capture_active <= 0, capture_done pulses 1 cycle, FSM -> IDLE.
- First window begins at the first tick after entering CAPTURE. Consecutive writes are exactly SAMPLE_COUNT*CLK_COUNT clocks apart (4096).
- led bits stay set after capture ends; only rst or a new start clears them.
- Start edge while in CAPTURE: ignored, no restart.
- rst mid-capture: immediate return to IDLE, all outputs 0, no further writes, no capture_done.
- Start edge coinciding with a tick: the tick is not counted; counting begins at the following tick.
- m_data is sampled only on tick; glitches between ticks have no effect.

Test Plan (RAM_SIZE=4, CLK_FREQ=100):
- Reset then idle 200 clocks -> m_clk toggles with period 32 and 16 high/16 low; ram_we, capture_active, capture_done and led all 0.
- m_data held 1, pulse start_capture -> four writes, addresses 0,1,2,3, each ram_wrdata=128, spaced 4096 clocks; capture_done pulses once one cycle after the address-3 write; capture_active falls with it.
- m_data toggled every m_clk period (1,0,1,0...) -> every ram_wrdata=64. Stuck 0 -> every ram_wrdata=0.
- m_data = 1 for the first 37 ticks of each window, then 0 -> ram_wrdata=37. Window boundaries checked against the write strobe.
- Second start pulse 1000 clocks into a capture -> no restart; still exactly 4 writes with unchanged timing.
- rst asserted between the 2nd and 3rd write -> no further ram_we, no capture_done, led=0. A subsequent start captures 4 words from address 0.
